// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice.
// Operands are latched on start and fed to the slice LSB first, one bit pair per
// cycle. Carry/borrow are held in registers between bits, and slice results are
// shifted into the result register from the top.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             zero,
    output logic             alu_a0,
    output logic             alu_b0,
    output logic             alu_c_in,
    output logic             alu_b_in,
    output logic [2:0]       alu_sel,
    input  logic             alu_y,
    input  logic             alu_c_out,
    input  logic             alu_b_out
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] shifted;

    // Result register after this cycle's slice bit enters at the MSB.
    assign shifted = {alu_y, result_q[WIDTH-1:1]};

    // Next-state logic: accept in idle, shift one bit per run cycle, finalise flags.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flag_d   = flag_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                result_d = shifted;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = alu_c_out;
                borrow_d = alu_b_out;
                cnt_d    = cnt_q + 1'b1;
                // Previous op's flags stay visible until the new op starts shifting.
                if (cnt_q == '0) begin
                    flag_d = 1'b0;
                    zero_d = 1'b0;
                end
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    flag_d  = (op_q == 3'b000) ? alu_c_out :
                              (op_q == 3'b001) ? alu_b_out : 1'b0;
                    zero_d  = (shifted == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            zero_q   <= zero_d;
        end
    end

    // Host status and slice drives; slice inputs are forced low outside RUN.
    always_comb begin
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        result   = result_q;
        flag     = flag_q;
        zero     = zero_q;
        alu_a0   = busy & a_q[0];
        alu_b0   = busy & b_q[0];
        alu_c_in = busy & carry_q;
        alu_b_in = busy & borrow_q;
        alu_sel  = busy ? op_q : 3'b000;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
- Sequencer that drives the team's 1-bit ALU slice bit-serially, LSB first, to execute WIDTH-bit operations.
- Latches operands and opcode on start, then feeds one bit pair per cycle to the slice.
- Holds carry and borrow in registers between bits, and shifts slice results into a WIDTH-bit result register.
- Sits between a host (start/done handshake) and one external 1-bit ALU slice instance.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
op  input  3  slice select: 000 add, 001 sub, 010 and, 011 nor, 111 xor, others produce 0
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/flag/zero valid
result  output  WIDTH  operation result; held until next accepted start
flag  output  1  add: final carry-out; sub: final borrow-out (a<b unsigned); other ops: 0
zero  output  1  result==0, updated with done
alu_a0  output  1  current A bit to slice
alu_b0  output  1  current B bit to slice
alu_c_in  output  1  carry register to slice
alu_b_in  output  1  borrow register to slice
alu_sel  output  3  latched opcode to slice
alu_y  input  1  slice result bit
alu_c_out  input  1  slice carry-out
alu_b_out  input  1  slice borrow-out

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; busy=0, done=0, result=0, flag=0, zero=0.
  - carry/borrow regs = 0; bit counter = 0.
  - alu_* outputs = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge k: latch a into shift reg A, b into shift reg B, op into op_reg.
  - Also clear carry/borrow regs and the counter, then go to RUN.
  - result, flag and zero are not cleared until the first RUN shift.
- RUN (cycles k+1 .. k+WIDTH):
  - busy=1.
  - Slice drives are combinational from registers: alu_a0=A[0], alu_b0=B[0], alu_c_in=carry, alu_b_in=borrow, alu_sel=op_reg.
  - Each edge:
    - result <= {alu_y, result[WIDTH-1:1]}
    - A and B shift right one bit
    - carry <= alu_c_out; borrow <= alu_b_out
    - counter++
  - When counter==WIDTH-1 at an edge, go to DONE.
- DONE (cycle k+WIDTH+1):
  - done=1, busy=0.
  - flag = carry if op_reg==000, borrow if op_reg==001, else 0; zero=(result==0).
  - flag and zero are registered on RUN→DONE and held until the next start.
  - Next edge: go to IDLE unconditionally.
- Latency: done asserted exactly WIDTH+1 cycles after the accepting edge. Throughput: one op per WIDTH+2 cycles.
- Boundary conditions:
  - start while RUN or DONE: ignored, no queueing; a/b/op are not resampled.
  - start held high continuously: a new op is accepted on the first IDLE cycle after DONE.
  - Add/sub wrap modulo 2^WIDTH; overflow is reported only via flag.
  - Unlisted op codes (100, 101, 110): the slice returns 0, so result=0, zero=1, flag=0.
  - Carry/borrow update in every op, but flag is masked per op.
  - alu_* outputs = 0 whenever state != RUN.
- rst mid-RUN or in DONE: abort to reset values next edge; no done pulse for the aborted op.
- The slice is purely combinational; no internal timing assumption beyond single-cycle combinational settle.

Test Plan:
- Reset: rst=1 two cycles → busy=0, done=0, result=0, flag=0, zero=0, alu_*=0.
- Add, WIDTH=8: op=000, a=8'h5A, b=8'h3C → done 9 cycles after start, result=8'h96, flag=0, zero=0.
- Add wrap: a=8'hFF, b=8'h01 → result=8'h00, flag=1, zero=1.
- Sub, op=001:
  - a=8'h10, b=8'h01 → result=8'h0F, flag=0.
  - a=8'h01, b=8'h02 → result=8'hFF, flag=1.
- Logic and unused ops:
  - xor: a=8'hA5, b=8'hFF → 8'h5A.
  - and: 8'hF0 & 8'h3C → 8'h30.
  - nor: 8'hF0, 8'h0C → 8'h03.
  - op=100 → 8'h00, zero=1, flag=0.
- Handshake and reset:
  - start pulsed at RUN cycle 3 with different a/b → ignored, original result unchanged.
  - rst at RUN cycle 4 → no done, outputs return to reset values, next start runs cleanly.
